issue_select_arbiter: RTL and testbench

// - Select stage of the scheduler, paired with WakeupLogic. Takes its per-row request_vector and picks at most one
//   row per functional unit (FU) per cycle, using a per-FU round-robin pointer.
// - Tracks row->FU binding, issued state and per-FU busy time (non-pipelined FUs).
// - Drives registered issue grants, row-free strobes and dependency-clear strobes back to wakeup/dispatch.

---
 rtl/issue_select_arbiter_pkg.sv | 26 ++
 rtl/issue_select_arbiter_if.sv | 34 +++
 rtl/issue_select_arbiter_rr_pick.sv | 33 +++
 rtl/issue_select_arbiter.sv | 116 +++++++++++
 tb/tb_issue_select_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_select_arbiter_pkg.sv
// Shared parameters and types for the issue-select stage.
//   NUM_ROWS / NUM_FUS : scheduler entries / functional units (powers of 2)
//   LAT_W              : width of per-FU latency and busy counters
//   pick_t             : result of a round-robin search (found + row index)
package issue_select_arbiter_pkg;

   localparam int NUM_ROWS = 8;
   localparam int NUM_FUS  = 4;
   localparam int LAT_W    = 8;
   localparam int ROW_W    = $clog2(NUM_ROWS);
   localparam int FU_W     = $clog2(NUM_FUS);

   typedef logic [ROW_W-1:0] row_idx_t;
   typedef logic [FU_W-1:0]  fu_idx_t;
   typedef logic [LAT_W-1:0] lat_t;

   typedef struct packed {
      logic     found;
      row_idx_t row;
   } pick_t;

   function automatic logic [NUM_ROWS-1:0] row_onehot(input row_idx_t r);
      return NUM_ROWS'(1) << r;
   endfunction

endpackage

// File: rtl/issue_select_arbiter_if.sv
// Bus between dispatch/wakeup (master) and the issue-select arbiter (slave).
//   flush, alloc_*, request_vector, fu_*   : master -> arbiter
//   issue_valid/row, free_mask, clear_en   : arbiter -> master, registered
//   alloc_err                              : sticky allocation error
interface issue_select_arbiter_if;
   import issue_select_arbiter_pkg::*;

   logic                             flush;
   logic                             alloc_en;
   row_idx_t                         alloc_row;
   fu_idx_t                          alloc_fu;
   logic [NUM_ROWS-1:0]              request_vector;
   logic [NUM_FUS-1:0]               fu_stall;
   logic [NUM_FUS-1:0]               fu_pipelined;
   logic [NUM_FUS-1:0][LAT_W-1:0]    fu_latency;
   logic [NUM_FUS-1:0]               issue_valid;
   logic [NUM_FUS-1:0][ROW_W-1:0]    issue_row;
   logic [NUM_ROWS-1:0]              free_mask;
   logic [NUM_FUS-1:0]               clear_en;
   logic                             alloc_err;

   modport master (
      output flush, alloc_en, alloc_row, alloc_fu, request_vector,
             fu_stall, fu_pipelined, fu_latency,
      input  issue_valid, issue_row, free_mask, clear_en, alloc_err
   );

   modport slave (
      input  flush, alloc_en, alloc_row, alloc_fu, request_vector,
             fu_stall, fu_pipelined, fu_latency,
      output issue_valid, issue_row, free_mask, clear_en, alloc_err
   );

endinterface

// File: rtl/issue_select_arbiter_rr_pick.sv
// Round-robin finder: first set bit of req searching ptr, ptr+1, ... with
// wrap modulo N.
//   req   : candidate vector
//   ptr   : search start index
//   found : any candidate present
//   idx   : index of the chosen candidate (0 when none)
module rr_pick #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W-1:0] k;

   // N is a power of two, so W-bit addition gives the modulo wrap for free.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      k     = '0;
      for (int i = 0; i < N; i++) begin
         k = ptr + W'(i);
         if (!found && req[k]) begin
            found = 1'b1;
            idx   = k;
         end
      end
   end

endmodule

// File: rtl/issue_select_arbiter.sv
// Select stage of the scheduler. Per cycle, each FU picks at most one eligible
// row via its own round-robin pointer; grants, freed rows and dependency-clear
// strobes are registered and appear one cycle after the request is seen.
//   clk, rst : clock, synchronous active-low reset
//   bus      : issue_select_arbiter_if.slave (alloc / request / FU status in,
//              issue grants / free / clear / alloc_err out)
module issue_select_arbiter
   import issue_select_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   issue_select_arbiter_if.slave bus
);

   // Row tables
   logic [NUM_ROWS-1:0]            valid_q;
   logic [NUM_ROWS-1:0]            issued_q;
   fu_idx_t                        fu_of_q [NUM_ROWS];

   // Per-FU state
   logic [NUM_FUS-1:0][ROW_W-1:0]  ptr_q;
   logic [NUM_FUS-1:0][LAT_W-1:0]  busy_q;

   // Output registers
   logic [NUM_FUS-1:0]             issue_valid_q;
   logic [NUM_FUS-1:0][ROW_W-1:0]  issue_row_q;
   logic [NUM_ROWS-1:0]            free_q;
   logic [NUM_FUS-1:0]             clear_q;
   logic                           err_q;

   logic [NUM_FUS-1:0][NUM_ROWS-1:0] elig;
   pick_t [NUM_FUS-1:0]              pick;
   logic [NUM_FUS-1:0]               grant;
   logic [NUM_ROWS-1:0]              free_nxt;
   logic [NUM_ROWS-1:0]              alloc_set;
   logic                             alloc_hit;

   for (genvar f = 0; f < NUM_FUS; f++) begin : g_fu
      for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
         // issued_q masks the one-cycle lag of request_vector after a grant
         assign elig[f][r] = bus.request_vector[r] & valid_q[r] & ~issued_q[r]
                           & (fu_of_q[r] == FU_W'(f));
      end

      rr_pick #(.N(NUM_ROWS)) u_pick (
         .req   (elig[f]),
         .ptr   (ptr_q[f]),
         .found (pick[f].found),
         .idx   (pick[f].row)
      );

      assign grant[f] = pick[f].found & ~bus.fu_stall[f] & (busy_q[f] == '0);
   end

   // Rows bind to one FU, so grants never collide on a row.
   always_comb begin
      free_nxt = '0;
      for (int f = 0; f < NUM_FUS; f++)
         if (grant[f]) free_nxt |= row_onehot(pick[f].row);
   end

   assign alloc_hit = bus.alloc_en & valid_q[bus.alloc_row];
   assign alloc_set = (bus.alloc_en & ~valid_q[bus.alloc_row])
                    ? row_onehot(bus.alloc_row) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q       <= '0;
         issued_q      <= '0;
         for (int r = 0; r < NUM_ROWS; r++) fu_of_q[r] <= '0;
         ptr_q         <= '0;
         busy_q        <= '0;
         issue_valid_q <= '0;
         issue_row_q   <= '0;
         free_q        <= '0;
         clear_q       <= '0;
         err_q         <= 1'b0;
      end else if (bus.flush) begin
         // pointers and the error flag survive a flush
         valid_q       <= '0;
         issued_q      <= '0;
         busy_q        <= '0;
         issue_valid_q <= '0;
         issue_row_q   <= '0;
         free_q        <= '0;
         clear_q       <= '0;
      end else begin
         issue_valid_q <= grant;
         clear_q       <= grant;
         free_q        <= free_nxt;
         for (int f = 0; f < NUM_FUS; f++) begin
            issue_row_q[f] <= grant[f] ? pick[f].row : '0;
            if (grant[f]) begin
               ptr_q[f]  <= pick[f].row + 1'b1;
               // latency 0/1 behaves as pipelined
               busy_q[f] <= (!bus.fu_pipelined[f] && bus.fu_latency[f] > LAT_W'(1))
                            ? bus.fu_latency[f] - 1'b1 : '0;
            end else if (busy_q[f] != '0) begin
               busy_q[f] <= busy_q[f] - 1'b1;
            end
         end
         // A granted row is valid, so alloc_set never overlaps free_nxt.
         valid_q  <= (valid_q & ~free_nxt) | alloc_set;
         issued_q <= (issued_q | free_nxt) & ~alloc_set;
         if (alloc_set != '0) fu_of_q[bus.alloc_row] <= bus.alloc_fu;
         if (alloc_hit) err_q <= 1'b1;
      end
   end

   assign bus.issue_valid = issue_valid_q;
   assign bus.issue_row   = issue_row_q;
   assign bus.free_mask   = free_q;
   assign bus.clear_en    = clear_q;
   assign bus.alloc_err   = err_q;

endmodule

// File: tb/tb_issue_select_arbiter.sv
// Bench for issue_select_arbiter: directed scenarios plus a randomized run
// checked against a behavioural model of the row/FU scheduling rules.
module tb_issue_select_arbiter;
   import issue_select_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   issue_select_arbiter_if bus();

   issue_select_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int passed = 0;

   // behavioural model state
   bit                 m_valid  [NUM_ROWS];
   bit                 m_issued [NUM_ROWS];
   int                 m_fu     [NUM_ROWS];
   int                 m_ptr    [NUM_FUS];
   int                 m_busy   [NUM_FUS];
   bit                 m_err;
   bit [NUM_FUS-1:0]   e_iv;
   int                 e_row    [NUM_FUS];
   bit [NUM_ROWS-1:0]  e_free;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush          = 1'b0;
      bus.alloc_en       = 1'b0;
      bus.alloc_row      = '0;
      bus.alloc_fu       = '0;
      bus.request_vector = '0;
      bus.fu_stall       = '0;
      bus.fu_pipelined   = '1;
      bus.fu_latency     = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic alloc(input int r, input int f);
      bus.alloc_en  = 1'b1;
      bus.alloc_row = row_idx_t'(r);
      bus.alloc_fu  = fu_idx_t'(f);
      tick();
      bus.alloc_en  = 1'b0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < NUM_ROWS; r++) begin
         m_valid[r] = 0; m_issued[r] = 0; m_fu[r] = 0;
      end
      for (int f = 0; f < NUM_FUS; f++) begin
         m_ptr[f] = 0; m_busy[f] = 0; e_row[f] = 0;
      end
      m_err = 0; e_iv = '0; e_free = '0;
   endtask

   // One clock of the scheduling rules, evaluated on the inputs now driven.
   task automatic model_step();
      bit a_ok, a_bad;
      int r, lat;
      e_iv = '0; e_free = '0;
      if (bus.flush) begin
         for (int i = 0; i < NUM_ROWS; i++) begin m_valid[i] = 0; m_issued[i] = 0; end
         for (int f = 0; f < NUM_FUS; f++) m_busy[f] = 0;
      end else begin
         a_ok  = bus.alloc_en && !m_valid[bus.alloc_row];
         a_bad = bus.alloc_en &&  m_valid[bus.alloc_row];
         for (int f = 0; f < NUM_FUS; f++) begin
            if (!bus.fu_stall[f] && m_busy[f] == 0) begin
               for (int i = 0; i < NUM_ROWS; i++) begin
                  r = (m_ptr[f] + i) % NUM_ROWS;
                  if (bus.request_vector[r] && m_valid[r] && !m_issued[r] && m_fu[r] == f) begin
                     e_iv[f] = 1; e_row[f] = r;
                     break;
                  end
               end
            end
         end
         for (int f = 0; f < NUM_FUS; f++) begin
            if (e_iv[f]) begin
               r = e_row[f];
               m_valid[r] = 0; m_issued[r] = 1; e_free[r] = 1;
               m_ptr[f] = (r + 1) % NUM_ROWS;
               lat = int'(bus.fu_latency[f]);
               m_busy[f] = (!bus.fu_pipelined[f] && lat > 1) ? lat - 1 : 0;
            end else if (m_busy[f] > 0) begin
               m_busy[f] = m_busy[f] - 1;
            end
         end
         if (a_ok) begin
            m_valid[bus.alloc_row] = 1; m_issued[bus.alloc_row] = 0;
            m_fu[bus.alloc_row] = int'(bus.alloc_fu);
         end
         if (a_bad) m_err = 1;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      bus.request_vector = '1;
      bus.alloc_en = 1'b1;
      tick();
      tick();
      checks++; if (bus.issue_valid !== 4'h0) $display("FAIL reset_issue_valid: got %0h want 0", bus.issue_valid); else passed++;
      checks++; if (bus.free_mask !== 8'h00) $display("FAIL reset_free_mask: got %0h want 0", bus.free_mask); else passed++;
      checks++; if (bus.clear_en !== 4'h0 || bus.alloc_err !== 1'b0) $display("FAIL reset_clear_err: got %0h/%0b want 0/0", bus.clear_en, bus.alloc_err); else passed++;
      idle_inputs();
      rst = 1'b1;
      alloc(2, 1);
      bus.request_vector = 8'h04;
      tick();
      checks++; if (bus.issue_valid !== 4'b0010 || bus.issue_row[1] !== 2'd2) $display("FAIL reset_first_grant: got v=%0h row=%0d want v=2 row=2", bus.issue_valid, bus.issue_row[1]); else passed++;
      checks++; if (bus.free_mask !== 8'h04 || bus.clear_en !== 4'b0010) $display("FAIL reset_first_free: got free=%0h clr=%0h want 04/2", bus.free_mask, bus.clear_en); else passed++;
      tick();
      checks++; if (bus.issue_valid !== 4'h0) $display("FAIL reset_single_pulse: got %0h want 0", bus.issue_valid); else passed++;
      // reset while a grant is about to be registered
      bus.request_vector = 8'h10;
      alloc(4, 0);
      rst = 1'b0;
      tick();
      checks++; if (bus.issue_valid !== 4'h0 || bus.free_mask !== 8'h00) $display("FAIL reset_midop: got v=%0h free=%0h want 0/0", bus.issue_valid, bus.free_mask); else passed++;
      rst = 1'b1;
   endtask

   task automatic test_round_robin();
      int exp_rows [5] = '{0, 3, 5, 7, 2};
      do_reset();
      alloc(0, 0); alloc(3, 0); alloc(5, 0);
      bus.request_vector = 8'h29;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.issue_valid[0] !== 1'b1 || bus.issue_row[0] !== ROW_W'(exp_rows[i])) $display("FAIL rr_grant%0d: got v=%0b row=%0d want v=1 row=%0d", i, bus.issue_valid[0], bus.issue_row[0], exp_rows[i]); else passed++;
      end
      tick();
      checks++; if (bus.issue_valid[0] !== 1'b0) $display("FAIL rr_no_regrant: got %0b want 0", bus.issue_valid[0]); else passed++;
      alloc(7, 0); alloc(2, 0);
      bus.request_vector = 8'h84;
      for (int i = 3; i < 5; i++) begin
         tick();
         checks++; if (bus.issue_valid[0] !== 1'b1 || bus.issue_row[0] !== ROW_W'(exp_rows[i])) $display("FAIL rr_wrap%0d: got v=%0b row=%0d want v=1 row=%0d", i, bus.issue_valid[0], bus.issue_row[0], exp_rows[i]); else passed++;
      end
   endtask

   task automatic test_nonpipelined();
      int t1 = -1;
      int t4 = -1;
      do_reset();
      bus.fu_pipelined[2] = 1'b0;
      bus.fu_latency[2]   = 8'd4;
      alloc(1, 2); alloc(4, 2);
      bus.request_vector = 8'h12;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (bus.issue_valid[2]) begin
            if (bus.issue_row[2] == 2'(1) && t1 < 0) t1 = c;
            else if (bus.issue_row[2] == ROW_W'(4) && t4 < 0) t4 = c;
         end
      end
      checks++; if (t1 !== 0) $display("FAIL np_first: got cycle %0d want 0", t1); else passed++;
      checks++; if (t4 !== t1 + 4) $display("FAIL np_second: got cycle %0d want %0d", t4, t1 + 4); else passed++;
   endtask

   task automatic test_stall_lag();
      do_reset();
      alloc(0, 0);
      bus.request_vector = 8'h01;
      bus.fu_stall[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.issue_valid[0] !== 1'b0) $display("FAIL stall_%0d: got %0b want 0", i, bus.issue_valid[0]); else passed++;
      end
      bus.fu_stall[0] = 1'b0;
      tick();
      checks++; if (bus.issue_valid[0] !== 1'b1 || bus.issue_row[0] !== 3'd0) $display("FAIL stall_release: got v=%0b row=%0d want 1/0", bus.issue_valid[0], bus.issue_row[0]); else passed++;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.issue_valid !== 4'h0) $display("FAIL lag_dup_%0d: got %0h want 0", i, bus.issue_valid); else passed++;
      end
   endtask

   task automatic test_flush();
      do_reset();
      bus.fu_pipelined[3] = 1'b0;
      bus.fu_latency[3]   = 8'd6;
      alloc(6, 3); alloc(5, 3); alloc(1, 0);
      bus.request_vector = 8'h40;
      tick();
      checks++; if (bus.issue_valid !== 4'b1000 || bus.issue_row[3] !== 3'd6) $display("FAIL flush_pre: got v=%0h row=%0d want 8/6", bus.issue_valid, bus.issue_row[3]); else passed++;
      bus.request_vector = 8'h22;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.request_vector = '0;
      checks++; if (bus.issue_valid !== 4'h0 || bus.free_mask !== 8'h00 || bus.clear_en !== 4'h0) $display("FAIL flush_outputs: got v=%0h free=%0h clr=%0h want 0", bus.issue_valid, bus.free_mask, bus.clear_en); else passed++;
      alloc(5, 3);
      checks++; if (bus.alloc_err !== 1'b0) $display("FAIL flush_realloc_err: got %0b want 0", bus.alloc_err); else passed++;
      bus.request_vector = 8'h20;
      tick();
      checks++; if (bus.issue_valid !== 4'b1000 || bus.issue_row[3] !== 3'd5) $display("FAIL flush_regrant: got v=%0h row=%0d want 8/5", bus.issue_valid, bus.issue_row[3]); else passed++;
   endtask

   task automatic test_alloc_err();
      do_reset();
      alloc(3, 1);
      alloc(3, 2);
      checks++; if (bus.alloc_err !== 1'b1) $display("FAIL err_set: got %0b want 1", bus.alloc_err); else passed++;
      bus.request_vector = 8'h08;
      tick();
      checks++; if (bus.issue_valid !== 4'b0010 || bus.issue_row[1] !== 3'd3) $display("FAIL err_table_kept: got v=%0h row=%0d want 2/3", bus.issue_valid, bus.issue_row[1]); else passed++;
      bus.request_vector = '0;
      tick(); tick();
      checks++; if (bus.alloc_err !== 1'b1) $display("FAIL err_sticky: got %0b want 1", bus.alloc_err); else passed++;
   endtask

   task automatic test_random();
      int r;
      do_reset();
      model_reset();
      bus.fu_pipelined = NUM_FUS'($urandom);
      for (int f = 0; f < NUM_FUS; f++) bus.fu_latency[f] = LAT_W'($urandom_range(0, 5));
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, NUM_ROWS - 1);
         bus.alloc_row      = row_idx_t'(r);
         bus.alloc_fu       = fu_idx_t'($urandom_range(0, NUM_FUS - 1));
         bus.alloc_en       = ($urandom_range(0, 2) != 0) && (!m_valid[r] || $urandom_range(0, 50) == 0);
         bus.request_vector = NUM_ROWS'($urandom);
         for (int f = 0; f < NUM_FUS; f++) bus.fu_stall[f] = ($urandom_range(0, 4) == 0);
         bus.flush          = ($urandom_range(0, 60) == 0);
         model_step();
         tick();
         checks++; if (bus.issue_valid !== e_iv || bus.clear_en !== e_iv) $display("FAIL rnd_valid c%0d: got v=%0h clr=%0h want %0h", c, bus.issue_valid, bus.clear_en, e_iv); else passed++;
         checks++; if (bus.free_mask !== e_free) $display("FAIL rnd_free c%0d: got %0h want %0h", c, bus.free_mask, e_free); else passed++;
         checks++; if (bus.alloc_err !== m_err) $display("FAIL rnd_err c%0d: got %0b want %0b", c, bus.alloc_err, m_err); else passed++;
         for (int f = 0; f < NUM_FUS; f++)
            if (e_iv[f]) begin
               checks++; if (bus.issue_row[f] !== ROW_W'(e_row[f])) $display("FAIL rnd_row c%0d fu%0d: got %0d want %0d", c, f, bus.issue_row[f], e_row[f]); else passed++;
            end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_nonpipelined();
      test_stall_lag();
      test_flush();
      test_alloc_err();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
      $fatal(1);
   end

endmodule
